// File: rtl/gol_pkg.sv
// Shared types and default sizing for the Game of Life generation scheduler.
package gol_pkg;

  localparam int unsigned SeedFramesDefault = 2;
  localparam int unsigned DivW              = 4;
  localparam int unsigned GenW              = 16;

  // Encoding is visible on the debug/LED output, so it is fixed explicitly.
  typedef enum logic [1:0] {
    StSeed  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StStep  = 2'd3
  } gol_state_e;

endpackage

// File: rtl/gol_frame_div.sv
// Frame-rate divider: counts generation boundaries and flags when the live
// divide value has been reached or overtaken.
module gol_frame_div
  import gol_pkg::*;
#(
  parameter int unsigned DIV_W = DivW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  // >= rather than == so a div lowered below the running count fires at once.
  assign tick_o = (cnt_q >= div_i);

  // Count boundaries; wrap to zero on the boundary that ticks.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (adv_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/gol_gen_sched.sv
// Once-per-frame scheduler deciding whether the board pass evolves or holds,
// plus seeding, run/pause/single-step control and speed division.
module gol_gen_sched
  import gol_pkg::*;
#(
  parameter int unsigned SEED_FRAMES = SeedFramesDefault,
  parameter int unsigned DIV_W       = DivW,
  parameter int unsigned GEN_W       = GenW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             da,
  input  logic             run,
  input  logic             step,
  input  logic             reseed,
  input  logic [DIV_W-1:0] div,
  output logic             cell_ena,
  output logic             evolve,
  output logic             seed,
  output logic [GEN_W-1:0] gen_count,
  output logic [1:0]       state
);

  localparam int unsigned SeedCntW = (SEED_FRAMES < 2) ? 1 : $clog2(SEED_FRAMES);
  localparam logic [SeedCntW-1:0] SeedLast = SeedCntW'(SEED_FRAMES - 1);

  gol_state_e          state_q;
  logic [SeedCntW-1:0] seed_cnt_q;
  logic                step_q;
  logic                reseed_q;
  logic                step_req;
  logic                reseed_req;
  logic                div_adv;
  logic                div_clr;
  logic                div_tick;

  // A pulse coincident with frame_start is honoured at that same boundary.
  assign step_req   = step_q | step;
  assign reseed_req = reseed_q | reseed;

  // Divider only advances on RUN boundaries that stay in RUN; any other
  // boundary leaves it at zero so a fresh RUN starts a full div+1 period.
  assign div_adv = frame_start && !reseed_req && (state_q == StRun) && run;
  assign div_clr = frame_start && !div_adv;

  gol_frame_div #(
    .DIV_W(DIV_W)
  ) u_frame_div (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (div_clr),
    .adv_i (div_adv),
    .div_i (div),
    .tick_o(div_tick)
  );

  assign state = state_q;

  // Scheduler FSM: request latches every cycle, decisions on frame_start only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StSeed;
      seed       <= 1'b1;
      evolve     <= 1'b0;
      cell_ena   <= 1'b0;
      gen_count  <= '0;
      seed_cnt_q <= '0;
      step_q     <= 1'b0;
      reseed_q   <= 1'b0;
    end else begin
      cell_ena <= da;
      if (!frame_start) begin
        if (step)   step_q   <= 1'b1;
        if (reseed) reseed_q <= 1'b1;
      end else begin
        step_q   <= step_req;
        reseed_q <= 1'b0;
        if (reseed_req) begin
          state_q    <= StSeed;
          seed       <= 1'b1;
          evolve     <= 1'b0;
          gen_count  <= '0;
          seed_cnt_q <= '0;
          step_q     <= 1'b0;
        end else begin
          unique case (state_q)
            StSeed: begin
              evolve <= 1'b0;
              if (seed_cnt_q == SeedLast) begin
                seed       <= 1'b0;
                gen_count  <= '0;
                seed_cnt_q <= '0;
                state_q    <= run ? StRun : StPause;
              end else begin
                seed_cnt_q <= seed_cnt_q + 1'b1;
              end
            end
            StRun: begin
              step_q <= 1'b0;
              if (!run) begin
                evolve  <= 1'b0;
                state_q <= StPause;
              end else if (div_tick) begin
                evolve    <= 1'b1;
                gen_count <= gen_count + 1'b1;
              end else begin
                evolve <= 1'b0;
              end
            end
            StPause: begin
              if (step_req) begin
                evolve  <= 1'b1;
                step_q  <= 1'b0;
                state_q <= StStep;
              end else begin
                evolve <= 1'b0;
                if (run) state_q <= StRun;
              end
            end
            StStep: begin
              // The frame that just ended carried the single evolved pass.
              gen_count <= gen_count + 1'b1;
              evolve    <= 1'b0;
              state_q   <= run ? StRun : StPause;
            end
            default: state_q <= StSeed;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gol_gen_sched.sv
// Self-checking bench for gol_gen_sched against a frame-level reference model.
module tb_gol_gen_sched;

  // Narrow generation counter so the wrap boundary is reachable in a short run.
  localparam int unsigned TbSeedFrames = 2;
  localparam int unsigned TbDivW       = 4;
  localparam int unsigned TbGenW       = 8;
  localparam int          GenMod       = 1 << TbGenW;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic              da;
  logic              run;
  logic              step;
  logic              reseed;
  logic [TbDivW-1:0] div;
  logic              cell_ena;
  logic              evolve;
  logic              seed;
  logic [TbGenW-1:0] gen_count;
  logic [1:0]        state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (frame level).
  int m_state, m_seed, m_evo, m_gen, m_dcnt, m_scnt, m_step, m_reseed, m_cell;

  gol_gen_sched #(
    .SEED_FRAMES(TbSeedFrames),
    .DIV_W      (TbDivW),
    .GEN_W      (TbGenW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .da         (da),
    .run        (run),
    .step       (step),
    .reseed     (reseed),
    .div        (div),
    .cell_ena   (cell_ena),
    .evolve     (evolve),
    .seed       (seed),
    .gen_count  (gen_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_seed = 1; m_evo = 0; m_gen = 0; m_dcnt = 0;
    m_scnt = 0; m_step = 0; m_reseed = 0; m_cell = 0;
  endtask

  // One clock edge of the reference: requests accumulate, frame boundaries decide.
  task automatic model_edge();
    int stp;
    int rsd;
    m_cell = int'(da);
    if (!frame_start) begin
      if (step)   m_step = 1;
      if (reseed) m_reseed = 1;
      return;
    end
    stp = (m_step != 0 || step) ? 1 : 0;
    rsd = (m_reseed != 0 || reseed) ? 1 : 0;
    m_reseed = 0;
    m_step = stp;
    if (rsd != 0) begin
      m_state = 0; m_seed = 1; m_evo = 0; m_gen = 0; m_dcnt = 0; m_scnt = 0; m_step = 0;
      return;
    end
    case (m_state)
      0: begin
        m_scnt++;
        if (m_scnt == int'(TbSeedFrames)) begin
          m_scnt = 0; m_seed = 0; m_gen = 0; m_dcnt = 0;
          m_state = run ? 1 : 2;
        end
      end
      1: begin
        m_step = 0;
        if (!run) begin
          m_state = 2; m_evo = 0; m_dcnt = 0;
        end else if (m_dcnt >= int'(div)) begin
          m_evo = 1; m_dcnt = 0; m_gen = (m_gen + 1) % GenMod;
        end else begin
          m_evo = 0; m_dcnt++;
        end
      end
      2: begin
        if (stp != 0) begin
          m_state = 3; m_evo = 1; m_step = 0;
        end else begin
          m_evo = 0;
          if (run) begin m_state = 1; m_dcnt = 0; end
        end
      end
      default: begin
        m_gen = (m_gen + 1) % GenMod; m_evo = 0; m_dcnt = 0;
        m_state = run ? 1 : 2;
      end
    endcase
  endtask

  task automatic compare_all();
    check_val("cell_ena", cell_ena, m_cell);
    check_val("evolve", evolve, m_evo);
    check_val("seed", seed, m_seed);
    check_val("state", state, m_state);
    check_val("gen_count", gen_count, m_gen);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      // Junk on the other inputs must be ignored while in reset.
      frame_start = 1'($urandom_range(0, 1));
      step        = 1'($urandom_range(0, 1));
      reseed      = 1'($urandom_range(0, 1));
      da          = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_reset();
      #1;
      compare_all();
    end
    rst = 1'b0; frame_start = 1'b0; step = 1'b0; reseed = 1'b0;
  endtask

  // One frame of len cycles; frame_start on the last cycle. Pulse positions < 0 mean none.
  task automatic run_frame(input int len, input int s0, input int s1, input int r0,
                           input bit rnd_da);
    for (int i = 0; i < len; i++) begin
      frame_start = (i == len - 1);
      da          = rnd_da ? 1'($urandom_range(0, 1)) : (i < len - 3);
      step        = (i == s0) || (i == s1);
      reseed      = (i == r0);
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
    frame_start = 1'b0; step = 1'b0; reseed = 1'b0;
  endtask

  initial begin
    int evo_cnt;
    int gen_base;
    int exp_st[6];
    int exp_ev[6];
    int len;
    int s0;
    int r0;

    rst = 1'b0; frame_start = 1'b0; da = 1'b0; run = 1'b1; step = 1'b0; reseed = 1'b0;
    div = '0;
    model_reset();

    // Reset and seeding, then evolve every frame with div=0.
    do_reset(3);
    check_val("rst_state", state, 0);
    check_val("rst_seed", seed, 1);
    run_frame(12, -1, -1, -1, 1'b0);
    check_val("seed_frame2", seed, 1);
    run_frame(12, -1, -1, -1, 1'b0);
    check_val("seed_done", seed, 0);
    check_val("seed_to_run", state, 1);
    for (int k = 0; k < 3; k++) begin
      run_frame(12, -1, -1, -1, 1'b0);
      check_val("div0_evolve", evolve, 1);
    end
    check_val("div0_gen3", gen_count, 3);

    // div=3: evolve on every fourth frame only.
    div = 4'd3;
    evo_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      run_frame(10, -1, -1, -1, 1'b0);
      check_val("div3_pattern", evolve, (k % 4 == 3) ? 1 : 0);
      if (evolve) evo_cnt++;
    end
    check_val("div3_count", evo_cnt, 3);
    check_val("div3_gen", gen_count, 6);

    // Pause and single-step.
    run = 1'b0;
    run_frame(10, -1, -1, -1, 1'b0);
    exp_st = '{2, 3, 2, 2, 3, 2};
    exp_ev = '{0, 1, 0, 0, 1, 0};
    for (int k = 0; k < 6; k++) begin
      check_val("step_state_seq", state, exp_st[k]);
      check_val("step_evolve_seq", evolve, exp_ev[k]);
      if (k == 0)      run_frame(10, 2, 5, -1, 1'b0);
      else if (k == 3) run_frame(10, 4, -1, -1, 1'b0);
      else             run_frame(10, -1, -1, -1, 1'b0);
    end
    check_val("step_gen", gen_count, 8);

    // Reseed coincident with frame_start while running at gen_count=7.
    run = 1'b1; div = '0;
    run_frame(10, -1, -1, 9, 1'b0);
    check_val("reseed_a_seed", seed, 1);
    run_frame(10, -1, -1, -1, 1'b0);
    run_frame(10, -1, -1, -1, 1'b0);
    check_val("reseed_a_run", state, 1);
    for (int k = 0; k < 7; k++) run_frame(8, -1, -1, -1, 1'b0);
    check_val("pre_reseed_gen", gen_count, 7);
    run_frame(8, -1, -1, 7, 1'b0);
    check_val("reseed_seed", seed, 1);
    check_val("reseed_evolve", evolve, 0);
    check_val("reseed_gen", gen_count, 0);
    check_val("reseed_state", state, 0);
    run_frame(8, -1, -1, -1, 1'b0);
    run_frame(8, -1, -1, -1, 1'b0);
    check_val("reseed_back_run", state, 1);

    // Mid-frame reset.
    run_frame(8, -1, -1, -1, 1'b0);
    da = 1'b1; @(posedge clk); model_edge(); #1; compare_all();
    do_reset(2);

    // Randomised control with random display-area toggling.
    for (int k = 0; k < 150; k++) begin
      len = int'($urandom_range(6, 20));
      s0  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      r0  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) div = 4'($urandom_range(0, 3));
      run_frame(len, s0, -1, r0, 1'b1);
    end

    // Generation counter wrap.
    run = 1'b1; div = '0;
    run_frame(4, -1, -1, 3, 1'b0);
    run_frame(4, -1, -1, -1, 1'b0);
    run_frame(4, -1, -1, -1, 1'b0);
    for (int k = 0; k < GenMod + 10 && m_gen != GenMod - 1; k++) run_frame(3, -1, -1, -1, 1'b0);
    check_val("wrap_pre", gen_count, GenMod - 1);
    gen_base = int'(state);
    run_frame(3, -1, -1, -1, 1'b0);
    check_val("wrap_gen", gen_count, 0);
    check_val("wrap_state", state, gen_base);
    check_val("wrap_seed", seed, 0);
    check_val("wrap_evolve", evolve, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gol_gen_sched.md
Name: gol_gen_sched

Overview:
Generation scheduler for the Game of Life board datapath. The board shifts one cell per enabled pixel clock, so one visible frame equals one pass over the board. This block decides, once per frame, whether that pass computes the next generation or recirculates the current one unchanged. It also sequences random seeding, run/pause/single-step control and speed division, and sits between the VGA timing generator and the board.

Parameters:
SEED_FRAMES, 2, number of whole frames the seed input is held high after reset or a reseed request
DIV_W, 4, width of the speed divider input
GEN_W, 16, width of the generation counter

Ports:
clk  in  1  pixel clock (VGA_CLK domain)
rst  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse on the first cycle after the last visible pixel of a frame
da  in  1  display-area flag from the timing generator
run  in  1  level: 1 = free-run, 0 = paused
step  in  1  pulse: request one generation while paused
reseed  in  1  pulse: request re-seeding from the LFSR
div  in  DIV_W  advance one generation every div+1 frames
cell_ena  out  1  board shift enable; equals da, registered, 1-cycle latency
evolve  out  1  1 = board writes newgen, 0 = board writes current cell (hold)
seed  out  1  drives the board's rst (random injection)
gen_count  out  GEN_W  generations computed since last seed
state  out  2  current FSM state, for debug/LEDs

Behaviour:
- Reset (rst=1 at a clk edge): state=SEED, seed=1, evolve=0, cell_ena=0, gen_count=0, frame counter=0, divider counter=0, step/reseed latches cleared.
- cell_ena <= da every cycle, irrespective of state (the display never blanks while paused).
- evolve and seed change only on the cycle after frame_start. They are constant across every visible pixel of a frame.
- Requests are latched: a step or reseed pulse on any cycle, including the same cycle as frame_start, sets its latch. Multiple pulses before a boundary collapse into one. A latch clears on the boundary that consumes it.
- FSM, evaluated at frame_start only:
  - SEED (state=0): seed=1, evolve=0. Count frames. After SEED_FRAMES boundaries, go to RUN if run=1, else PAUSE. Set seed=0 and gen_count=0.
  - RUN (state=1):
    - The divider counter increments each boundary. When it equals div: evolve=1 for the next frame, counter returns to 0, and gen_count increments; otherwise evolve=0.
    - If run=0, go to PAUSE with evolve=0 and counter=0.
  - PAUSE (state=2): evolve=0.
    - If the step latch is set: go to STEP, with evolve=1 for the next frame.
    - If run=1: go to RUN, counter=0.
  - STEP (state=3): the frame just ended was the evolving one. gen_count increments. Return to PAUSE (or RUN if run=1) with evolve=0.
- Priority at a boundary: reseed latch > state logic. Reseed enters SEED from any state, clears the counters and step latch, and sets seed=1 for the next frame.
- A step pulse while in RUN is discarded at the next boundary (latch cleared).
- div changing mid-count: compared against the live value. If the counter already exceeds the new div, evolve occurs at the next boundary and the counter resets.
- div=0: evolve every frame.
- gen_count wraps from 2^GEN_W-1 to 0 silently.
- rst mid-frame: outputs take reset values on the next edge. The board then seeds for the remainder of that frame plus SEED_FRAMES full frames.
- Inputs other than rst are ignored while rst=1.

Decomposition:
- Package gol_pkg:
  - state enum {SEED, RUN, PAUSE, STEP} encoded 0..3
  - default SEED_FRAMES
  - GEN_W and DIV_W constants
- One sub-module, gol_frame_div: the divider counter with a tick output, cleared by the parent. Everything else stays in gol_gen_sched.

Test Plan:
- rst for 3 cycles, run=1, div=0, SEED_FRAMES=2 -> seed=1 for exactly 2 frame_start boundaries. Then evolve=1 on every frame; gen_count=3 after 3 further boundaries.
- run=1, div=3 over 12 frames -> evolve high on frames 4, 8, 12 only; gen_count increments by 3.
- run=0 in PAUSE, two step pulses within one frame, then one more two frames later -> exactly 2 evolving frames total, each preceded and followed by evolve=0; state sequence 2,3,2,2,3,2.
- Reseed pulse coincident with frame_start while in RUN with gen_count=7 -> next frame seed=1, evolve=0, gen_count=0; returns to RUN after SEED_FRAMES boundaries.
- Toggle da randomly and pulse step mid-frame -> cell_ena tracks da with 1-cycle latency, and evolve never changes while da=1.
- Preload gen_count=16'hFFFF, one evolve frame -> gen_count=0, no other side effect.
